// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encoding and owner constants for the data memory arbiter
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   localparam logic OWNER_P0 = 1'b0;
   localparam logic OWNER_P1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way request arbiter, round-robin or fixed priority (DMEM_ARB_FIXED_PRIO_EN)
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = last;
`endif

   always_comb begin
      winner = OWNER_P0;
      if (req == 2'b10) begin
         winner = OWNER_P1;
      end else if (req == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
         winner = OWNER_P0;
`else
         winner = (last == OWNER_P0) ? OWNER_P1 : OWNER_P0;
`endif
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - serialises two requesters onto one single-port data memory
// Tie-break policy follows DMEM_ARB_FIXED_PRIO_EN inside rr_arb2.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int               CNT_W    = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic              mem_we_q, mem_we_d;
   logic              winner;
   logic              capture;

   rr_arb2 u_arb (
      .req    ({req1, req0}),
      .last   (last_q),
      .winner (winner)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         owner_q    <= OWNER_P0;
         last_q     <= OWNER_P1;
         cnt_q      <= '0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_we_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mem_we_q   <= mem_we_d;
      end
   end

   // In ISSUE, mem_we_q is the registered write flag of the access in flight
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req0 || req1) state_d = S_ISSUE;
         S_ISSUE: state_d = (mem_we_q || READ_LAT == 0) ? S_IDLE : S_WAIT;
         S_WAIT:  if (cnt_q == CNT_ONE) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      owner_d    = owner_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      rvalid0_d  = 1'b0;
      rvalid1_d  = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mem_we_d   = 1'b0;
      capture    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               owner_d    = winner;
               last_d     = winner;
               gnt0_d     = (winner == OWNER_P0);
               gnt1_d     = (winner == OWNER_P1);
               mem_addr_d = (winner == OWNER_P1) ? addr1 : addr0;
               mem_data_d = (winner == OWNER_P1) ? wdata1 : wdata0;
               mem_we_d   = (winner == OWNER_P1) ? we1 : we0;
            end
         end
         S_ISSUE: begin
            if (!mem_we_q) begin
               if (READ_LAT == 0) capture = 1'b1;
               else               cnt_d   = CNT_LOAD;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) capture = 1'b1;
         end
         default: ;
      endcase
      // rvalid lands in the first IDLE cycle, alongside any new arbitration
      if (capture) begin
         if (owner_q == OWNER_P1) begin
            rdata1_d  = mem_rdata;
            rvalid1_d = 1'b1;
         end else begin
            rdata0_d  = mem_rdata;
            rvalid0_d = 1'b1;
         end
      end
   end

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (READ_LAT=0 and READ_LAT=2 instances)
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic        sel = 1'b0;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic        a_gnt0, a_gnt1, a_rv0, a_rv1, a_mwe;
   logic [31:0] a_rd0, a_rd1, a_maddr, a_mdata, a_mrdata;
   logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_mwe;
   logic [31:0] b_rd0, b_rd1, b_maddr, b_mdata, b_mrdata;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(0)) dut_a (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(a_gnt0), .rvalid0(a_rv0), .rdata0(a_rd0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(a_gnt1), .rvalid1(a_rv1), .rdata1(a_rd1),
      .mem_addr(a_maddr), .mem_data(a_mdata), .mem_we(a_mwe), .mem_rdata(a_mrdata)
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(2)) dut_b (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(b_gnt0), .rvalid0(b_rv0), .rdata0(b_rd0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(b_gnt1), .rvalid1(b_rv1), .rdata1(b_rd1),
      .mem_addr(b_maddr), .mem_data(b_mdata), .mem_we(b_mwe), .mem_rdata(b_mrdata)
   );

   // Memories: combinational read for dut_a, two-stage read pipeline for dut_b
   logic [31:0] mem_a [64];
   logic [31:0] mem_b [64];
   logic [31:0] b_r1 = '0, b_r2 = '0;
   always @(posedge clk) if (a_mwe) mem_a[a_maddr[5:0]] <= a_mdata;
   always @(posedge clk) begin
      if (b_mwe) mem_b[b_maddr[5:0]] <= b_mdata;
      b_r1 <= mem_b[b_maddr[5:0]];
      b_r2 <= b_r1;
   end
   assign a_mrdata = mem_a[a_maddr[5:0]];
   assign b_mrdata = b_r2;

   logic        m_gnt0, m_gnt1, m_rv0, m_rv1, m_mwe;
   logic [31:0] m_rd0, m_rd1, m_maddr, m_mdata;
   assign m_gnt0  = sel ? b_gnt0  : a_gnt0;
   assign m_gnt1  = sel ? b_gnt1  : a_gnt1;
   assign m_rv0   = sel ? b_rv0   : a_rv0;
   assign m_rv1   = sel ? b_rv1   : a_rv1;
   assign m_mwe   = sel ? b_mwe   : a_mwe;
   assign m_rd0   = sel ? b_rd0   : a_rd0;
   assign m_rd1   = sel ? b_rd1   : a_rd1;
   assign m_maddr = sel ? b_maddr : a_maddr;
   assign m_mdata = sel ? b_mdata : a_mdata;

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } gexp_t;

   gexp_t       exp_g[$];
   logic [31:0] exp_rd0[$];
   logic [31:0] exp_rd1[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push_g(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d);
      gexp_t e;
      e.port = p; e.we = w; e.addr = a; e.data = d;
      exp_g.push_back(e);
   endtask

   task automatic push_rd(input int p, input logic [31:0] d);
      if (p == 0) exp_rd0.push_back(d);
      else        exp_rd1.push_back(d);
   endtask

   // Monitor: pops expectations whenever the selected DUT presents a grant or read result
   always @(negedge clk) begin
      gexp_t e;
      if (m_gnt0 || m_gnt1) begin
         if (exp_g.size() == 0) chk("gnt_unexpected", {30'd0, m_gnt1, m_gnt0}, 32'd0);
         else begin
            e = exp_g.pop_front();
            chk("gnt_port", {30'd0, m_gnt1, m_gnt0}, e.port ? 32'd2 : 32'd1);
            chk("gnt_mem_we", {31'd0, m_mwe}, {31'd0, e.we});
            chk("gnt_mem_addr", m_maddr, e.addr);
            if (e.we) chk("gnt_mem_data", m_mdata, e.data);
         end
      end
      if (m_rv0) begin
         if (exp_rd0.size() == 0) chk("rvalid0_unexpected", m_rd0, 32'hFFFF_FFFF);
         else chk("rdata0", m_rd0, exp_rd0.pop_front());
      end
      if (m_rv1) begin
         if (exp_rd1.size() == 0) chk("rvalid1_unexpected", m_rd1, 32'hFFFF_FFFF);
         else chk("rdata1", m_rd1, exp_rd1.pop_front());
      end
   end

   task automatic set_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   task automatic clr_req(input int p);
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
   endtask

   // Requester drops req on the negedge where it sees its grant
   task automatic wait_evt(input int p, input bit rv, output int c);
      c = -1000;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (!rv && ((p == 0 && m_gnt0) || (p == 1 && m_gnt1))) begin c = cyc; break; end
         if (rv && ((p == 0 && m_rv0) || (p == 1 && m_rv1))) begin c = cyc; break; end
      end
      if (!rv) clr_req(p);
      if (c < 0) begin
         checks++; errors++;
         $display("FAIL wait_timeout port=%0d rv=%0d: got no event expected one", p, rv);
      end
   endtask

   task automatic single(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int rv_lat, input string nm);
      int c0, cg, cr;
      push_g(p[0], w, a, d);
      @(posedge clk); #1;
      c0 = cyc;
      set_req(p, w, a, d);
      wait_evt(p, 1'b0, cg);
      chk({nm, "_gnt_lat"}, cg - c0, 1);
      if (!w) begin
         wait_evt(p, 1'b1, cr);
         chk({nm, "_rv_lat"}, cr - c0, rv_lat);
      end
   endtask

   task automatic do_reset();
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_flags"}, {27'd0, m_gnt0, m_gnt1, m_rv0, m_rv1, m_mwe}, 32'd0);
      chk({nm, "_rdata0"}, m_rd0, 32'd0);
      chk({nm, "_rdata1"}, m_rd1, 32'd0);
      chk({nm, "_mem_addr"}, m_maddr, 32'd0);
      chk({nm, "_mem_data"}, m_mdata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, c2, cg, cr, n, nrv;
      bit we_seen;

      // ---- READ_LAT=0 instance ----
      sel = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;

      // write then read back on port 0
      single(0, 1'b1, 32'h4, 32'hDEADBEEF, 0, "t1_wr");
      push_rd(0, 32'hDEADBEEF);
      single(0, 1'b0, 32'h4, 32'h0, 2, "t1_rd");
      single(1, 1'b1, 32'h8, 32'hCAFEF00D, 0, "t2_prep");

      // both ports hold read requests through four grants
      do_reset();
      push_g(1'b0, 1'b0, 32'h4, 32'h0); push_rd(0, 32'hDEADBEEF);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 3; k++) begin push_g(1'b0, 1'b0, 32'h4, 32'h0); push_rd(0, 32'hDEADBEEF); end
`else
      push_g(1'b1, 1'b0, 32'h8, 32'h0); push_rd(1, 32'hCAFEF00D);
      push_g(1'b0, 1'b0, 32'h4, 32'h0); push_rd(0, 32'hDEADBEEF);
      push_g(1'b1, 1'b0, 32'h8, 32'h0); push_rd(1, 32'hCAFEF00D);
`endif
      @(posedge clk); #1;
      c0 = cyc;
      set_req(0, 1'b0, 32'h4, 32'h0);
      set_req(1, 1'b0, 32'h8, 32'h0);
      n = 0; c1 = -1000; c2 = -1000;
      for (int i = 0; i < 20 && n < 4; i++) begin
         @(negedge clk);
         if (m_gnt0 || m_gnt1) begin
            n++;
            if (n == 1) c1 = cyc;
            if (n == 2) c2 = cyc;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("t5_grant_count", n, 4);
      chk("t2_first_gnt_lat", c1 - c0, 1);
      chk("t2_second_gnt_lat", c2 - c0, 3);
      repeat (3) @(negedge clk);

      // port1 write then port0 read of the same word, back to back
      push_g(1'b1, 1'b1, 32'h10, 32'h12345678);
      push_g(1'b0, 1'b0, 32'h10, 32'h0);
      push_rd(0, 32'h12345678);
      @(posedge clk); #1;
      c0 = cyc;
      set_req(1, 1'b1, 32'h10, 32'h12345678);
      wait_evt(1, 1'b0, cg);
      chk("t6_gnt1_lat", cg - c0, 1);
      set_req(0, 1'b0, 32'h10, 32'h0);
      wait_evt(0, 1'b0, cg);
      chk("t6_gnt0_lat", cg - c0, 3);
      wait_evt(0, 1'b1, cr);
      chk("t6_rv0_lat", cr - c0, 4);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      chk("t6_rdata1_kept", m_rd1, 32'h0);
`else
      chk("t6_rdata1_kept", m_rd1, 32'hCAFEF00D);
`endif

      // ---- READ_LAT=2 instance ----
      do_reset();
      sel = 1'b1;
      single(1, 1'b1, 32'h20, 32'h0BADF00D, 0, "t3_wr");
      push_g(1'b1, 1'b0, 32'h20, 32'h0);
      push_rd(1, 32'h0BADF00D);
      @(posedge clk); #1;
      c0 = cyc;
      set_req(1, 1'b0, 32'h20, 32'h0);
      we_seen = 1'b0; cg = -1000; cr = -1000;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (m_mwe) we_seen = 1'b1;
         if (m_gnt1) begin cg = cyc; req1 = 1'b0; end
         if (m_rv1) begin cr = cyc; break; end
      end
      req1 = 1'b0;
      chk("t3_gnt_lat", cg - c0, 1);
      chk("t3_rv_lat", cr - c0, 4);
      chk("t3_mem_we_low", {31'd0, we_seen}, 32'd0);

      // reset pulse while the read sits in WAIT
      push_g(1'b1, 1'b0, 32'h20, 32'h0);
      @(posedge clk); #1;
      c0 = cyc;
      set_req(1, 1'b0, 32'h20, 32'h0);
      wait_evt(1, 1'b0, cg);
      chk("t4_gnt_lat", cg - c0, 1);
      @(posedge clk); #1;
      chk("t4_pre_mem_addr", m_maddr, 32'h20);
      #2 rst = 1'b1;
      #1 chk_reset("t4_rst");
      @(negedge clk); #1 rst = 1'b0;
      nrv = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (m_rv0 || m_rv1 || m_gnt0 || m_gnt1) nrv++;
      end
      chk("t4_no_events", nrv, 0);
      push_rd(1, 32'h0BADF00D);
      single(1, 1'b0, 32'h20, 32'h0, 4, "t4_after");

      repeat (3) @(negedge clk);
      chk("sb_gnt_drained", exp_g.size(), 0);
      chk("sb_rd0_drained", exp_rd0.size(), 0);
      chk("sb_rd1_drained", exp_rd1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
